// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if
// Bundles the signals between the instruction prefetch unit and the rest of
// the core: the synchronous-ROM read port, the branch redirect request, the
// condition flags, and the instruction-register handshake.
//
// Signals:
//   rom_addr    [ADDR_W-1:0] word address to the ROM (fetch unit drives)
//   rom_data    [31:0]       ROM read data, one cycle after rom_addr
//   redirect                 flush the queue and restart fetch at redirect_pc
//   redirect_pc [31:0]       redirect target, low two bits ignored
//   NZCV        [3:0]        condition flags N,Z,C,V (bit3..bit0)
//   ir_ready                 consumer accepts the head instruction
//   ir_valid                 head instruction is being presented
//   IR          [31:0]       head instruction
//   PC          [31:0]       address of the head instruction
//   W_IR_valid               head instruction's condition passes
//
// Modports:
//   master - the fetch unit
//   slave  - the environment (ROM, core control, consumer)
interface fetch_prefetch_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [3:0]        NZCV;
  logic              ir_ready;
  logic              ir_valid;
  logic [31:0]       IR;
  logic [31:0]       PC;
  logic              W_IR_valid;

  modport master (
    output rom_addr, ir_valid, IR, PC, W_IR_valid,
    input  rom_data, redirect, redirect_pc, NZCV, ir_ready
  );

  modport slave (
    input  rom_addr, ir_valid, IR, PC, W_IR_valid,
    output rom_data, redirect, redirect_pc, NZCV, ir_ready
  );
endinterface

// File: rtl/fetch_prefetch.sv
// fetch_prefetch
// Instruction prefetch unit. A fetch pointer streams word reads out of a
// synchronous ROM (one-cycle latency) into a small instruction queue; the
// queue head is presented as IR/PC with a valid/ready handshake, and the
// head's ARM-style condition field is decoded against NZCV into W_IR_valid.
// A read is only issued when the queue has room for it counting the read
// already in flight, so the queue can never overflow.
//
// Parameters:
//   ADDR_W   ROM word-address width
//   DEPTH    queue entries (power of two, >= 2)
//   PC_RESET first fetch address
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   fetch_prefetch_if.master (ROM port, redirect, flags, IR handshake)
//
// Build option:
//   FETCH_COND_SKIP_EN - when defined, a head instruction whose condition
//   fails is dropped automatically instead of being presented, and
//   W_IR_valid simply mirrors ir_valid.
module fetch_prefetch #(
  parameter int          ADDR_W   = 6,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_prefetch_if.master    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fpc;
  logic [31:0]      flight_pc;
  logic             in_flight;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      q_ir [DEPTH];
  logic [31:0]      q_pc [DEPTH];

  logic             has_head;
  logic [31:0]      head_ir;
  logic [31:0]      head_pc;
  logic             cond_pass;
  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;

  // Condition decode: codes come in pass/inverse pairs, so pick the base
  // test from the upper three bits and flip it with bit 0. Code F is the
  // one exception, "always" like E.
  function automatic logic cond_ok(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (code[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (code == 4'hF) ? 1'b1 : (base ^ code[0]);
  endfunction

  assign has_head  = (count != '0);
  assign head_ir   = q_ir[rd_ptr];
  assign head_pc   = q_pc[rd_ptr];
  assign cond_pass = cond_ok(head_ir[31:28], bus.NZCV);

  // A slot is reserved for the read in flight, so issue only when the
  // queue plus the pending return still leaves room.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, in_flight};
  assign issue     = ~bus.redirect && (occupancy < DEPTH_OCC);
  assign push      = in_flight && ~bus.redirect;

`ifdef FETCH_COND_SKIP_EN
  assign pop            = has_head && ~bus.redirect && (~cond_pass || bus.ir_ready);
  assign bus.ir_valid   = has_head && cond_pass;
  assign bus.W_IR_valid = has_head && cond_pass;
`else
  assign pop            = has_head && ~bus.redirect && bus.ir_ready;
  assign bus.ir_valid   = has_head;
  assign bus.W_IR_valid = has_head && cond_pass;
`endif

  assign bus.IR       = has_head ? head_ir : 32'h0;
  assign bus.PC       = has_head ? head_pc : 32'h0;
  assign bus.rom_addr = fpc[ADDR_W+1:2];

  // Fetch pointer, in-flight tracking and queue bookkeeping. A redirect
  // wins over everything: it empties the queue, drops the pending read and
  // ignores any coincident pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc       <= PC_RESET;
      flight_pc <= 32'h0;
      in_flight <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (bus.redirect) begin
      fpc       <= bus.redirect_pc & ~32'h3;
      in_flight <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        flight_pc <= fpc;
        fpc       <= fpc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      q_ir[wr_ptr] <= bus.rom_data;
      q_pc[wr_ptr] <= flight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch
// Bench for fetch_prefetch with ADDR_W=6, DEPTH=4, PC_RESET=0. A 64-word
// synchronous ROM model feeds the DUT. The reference model only tracks the
// address the consumer must see next (reset value, +4 per accepted
// instruction, redirect target); IR is looked up in the ROM array and the
// condition result comes from a literal per-code table. Directed steps pin
// latency, stall depth, redirect flush, pointer wrap and condition cases.
module tb_fetch_prefetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] rom [64];
  logic [31:0] exp_pc;

  fetch_prefetch_if #(.ADDR_W(6)) bus ();

  fetch_prefetch #(
    .ADDR_W  (6),
    .DEPTH   (4),
    .PC_RESET(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: one-cycle read latency.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Condition table written out code by code.
  function automatic logic model_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = c;
      4'h3: r = !c;
      4'h4: r = n;
      4'h5: r = !n;
      4'h6: r = v;
      4'h7: r = !v;
      4'h8: r = c && !z;
      4'h9: r = !c || z;
      4'hA: r = (n == v);
      4'hB: r = (n != v);
      4'hC: r = !z && (n == v);
      4'hD: r = z || (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Address of the next instruction the consumer should see, starting from
  // pc: identity normally, skips failing instructions in the skip build.
  function automatic logic [31:0] skip_forward(input logic [31:0] pc);
    logic [31:0] p;
    p = pc;
`ifdef FETCH_COND_SKIP_EN
    begin
      logic done;
      done = 1'b0;
      for (int i = 0; i < 64; i++) begin
        if (!done) begin
          if (!model_cond(rom[p[7:2]][31:28], bus.NZCV)) p = p + 32'd4;
          else done = 1'b1;
        end
      end
    end
`endif
    return p;
  endfunction

  // Reference model: next expected PC.
  always @(posedge clk or negedge rst) begin
    if (!rst)
      exp_pc <= 32'h0;
    else if (bus.redirect)
      exp_pc <= {bus.redirect_pc[31:2], 2'b00};
    else if (bus.ir_valid)
      exp_pc <= skip_forward(exp_pc) + (bus.ir_ready ? 32'd4 : 32'd0);
  end

  // Compare process, every falling edge.
  always @(negedge clk) begin
    logic [31:0] want;
    if (!rst) begin
      check_output("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
      check_output("rst_IR", bus.IR, 32'h0);
      check_output("rst_PC", bus.PC, 32'h0);
      check_output("rst_W_IR_valid", 32'(bus.W_IR_valid), 32'h0);
      check_output("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    end else if (bus.ir_valid) begin
      want = skip_forward(exp_pc);
      check_output("model_PC", bus.PC, want);
      check_output("model_IR", bus.IR, rom[want[7:2]]);
`ifdef FETCH_COND_SKIP_EN
      check_output("model_W_IR_valid", 32'(bus.W_IR_valid), 32'h1);
`else
      check_output("model_W_IR_valid", 32'(bus.W_IR_valid),
                   32'(model_cond(rom[want[7:2]][31:28], bus.NZCV)));
`endif
    end else begin
      check_output("idle_W_IR_valid", 32'(bus.W_IR_valid), 32'h0);
`ifndef FETCH_COND_SKIP_EN
      check_output("idle_IR", bus.IR, 32'h0);
      check_output("idle_PC", bus.PC, 32'h0);
`endif
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'hE000_0000 + 32'(i);
    rom[40] = 32'hC000_0028;
    rom[41] = 32'hD000_0029;
    for (int k = 0; k < 16; k++) rom[42 + k] = (32'(k) << 28) | 32'(42 + k);

    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.NZCV        = 4'h0;
    bus.ir_ready    = 1'b1;
    repeat (3) step();

    // Reset state.
    check_output("reset_ir_valid", 32'(bus.ir_valid), 32'h0);
    check_output("reset_IR", bus.IR, 32'h0);
    check_output("reset_PC", bus.PC, 32'h0);
    check_output("reset_rom_addr", 32'(bus.rom_addr), 32'h0);

    // Streaming from reset: two-cycle latency, then one per cycle.
    rst = 1'b1;
    step();
    check_output("latency_edge0_valid", 32'(bus.ir_valid), 32'h0);
    step();
    check_output("latency_edge1_valid", 32'(bus.ir_valid), 32'h1);
    check_output("stream_PC0", bus.PC, 32'h0);
    check_output("stream_IR0", bus.IR, 32'hE000_0000);
    for (int k = 1; k < 8; k++) begin
      step();
      check_output("stream_valid", 32'(bus.ir_valid), 32'h1);
      check_output("stream_PC", bus.PC, 32'(4 * k));
      check_output("stream_IR", bus.IR, 32'hE000_0000 + 32'(k));
    end

    // Stall: head 28 held, four entries 28..40 buffered, fetch stops at 44.
    bus.ir_ready = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      step();
      check_output("stall_PC", bus.PC, 32'd28);
      if (s >= 3) check_output("stall_rom_addr", 32'(bus.rom_addr), 32'd11);
    end
    bus.ir_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_output("release_valid", 32'(bus.ir_valid), 32'h1);
      check_output("release_PC", bus.PC, 32'd28 + 32'(4 * k));
    end

    // Redirect with a read in flight.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h23;
    step();
    bus.redirect = 1'b0;
    check_output("redirect_flush_valid", 32'(bus.ir_valid), 32'h0);
    step();
    check_output("redirect_gap_valid", 32'(bus.ir_valid), 32'h0);
    step();
    check_output("redirect_PC", bus.PC, 32'h20);
    check_output("redirect_IR", bus.IR, 32'hE000_0008);
    step();
    check_output("redirect_next_PC", bus.PC, 32'h24);

    // Reset mid-stream: outputs clear immediately, restart from PC_RESET.
    rst = 1'b0;
    #1;
    check_output("async_rst_valid", 32'(bus.ir_valid), 32'h0);
    check_output("async_rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    step();
    rst = 1'b1;
    step();
    check_output("rerst_edge0_valid", 32'(bus.ir_valid), 32'h0);
    step();
    check_output("rerst_edge1_valid", 32'(bus.ir_valid), 32'h1);
    check_output("rerst_PC", bus.PC, 32'h0);

`ifndef FETCH_COND_SKIP_EN
    // Condition decode on a held head.
    bus.ir_ready    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hA0;
    step();
    bus.redirect = 1'b0;
    step();
    step();
    check_output("cond_head_PC", bus.PC, 32'hA0);
    check_output("cond_head_IR", bus.IR, 32'hC000_0028);
    bus.NZCV = 4'b0100;
    #1;
    check_output("cond_GT_Zset", 32'(bus.W_IR_valid), 32'h0);
    bus.NZCV = 4'b1001;
    #1;
    check_output("cond_GT_NeqV", 32'(bus.W_IR_valid), 32'h1);
    bus.ir_ready = 1'b1;
    step();
    bus.ir_ready = 1'b0;
    check_output("cond_LE_IR", bus.IR, 32'hD000_0029);
    bus.NZCV = 4'b1000;
    #1;
    check_output("cond_LE_NneV", 32'(bus.W_IR_valid), 32'h1);
    for (int k = 0; k < 16; k++) begin
      bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;
      check_output("sweep_PC", bus.PC, 32'hA8 + 32'(4 * k));
      for (int f = 0; f < 16; f++) begin
        bus.NZCV = 4'(f);
        #1;
        check_output("sweep_W_IR_valid", 32'(bus.W_IR_valid), 32'(model_cond(4'(k), 4'(f))));
      end
    end
`endif

    // Fetch pointer crossing the ROM size: rom_addr wraps, PC does not.
    bus.NZCV        = 4'h0;
    bus.ir_ready    = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFC;
    step();
    bus.redirect = 1'b0;
    check_output("wrap_rom_addr_63", 32'(bus.rom_addr), 32'd63);
    step();
    check_output("wrap_rom_addr_0", 32'(bus.rom_addr), 32'd0);
    step();
    check_output("wrap_PC_FC", bus.PC, 32'hFC);
    check_output("wrap_IR_FC", bus.IR, 32'hE000_003F);
    step();
    check_output("wrap_PC_100", bus.PC, 32'h100);
    check_output("wrap_IR_100", bus.IR, 32'hE000_0000);

    // Head with failing EQ (Z=0): dropped in the skip build, shown otherwise.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hA8;
    step();
    bus.redirect = 1'b0;
    step();
    step();
`ifdef FETCH_COND_SKIP_EN
    check_output("skip_drop_valid", 32'(bus.ir_valid), 32'h0);
    step();
    check_output("skip_next_valid", 32'(bus.ir_valid), 32'h1);
    check_output("skip_next_PC", bus.PC, 32'hAC);
`else
    check_output("noskip_valid", 32'(bus.ir_valid), 32'h1);
    check_output("noskip_PC", bus.PC, 32'hA8);
    check_output("noskip_W_IR_valid", 32'(bus.W_IR_valid), 32'h0);
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning instruction ROM word-address width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, >= 2).
REQ-003 The block SHALL have parameter PC_RESET, default 32'h0, meaning first fetch address.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rom_addr  output  ADDR_W  word address to the synchronous ROM (1-cycle read latency).
REQ-007 rom_data  input  32  ROM read data, valid the cycle after rom_addr is issued.
REQ-008 redirect  input  1  branch/flush request.
REQ-009 redirect_pc  input  32  target of redirect; bits [1:0] ignored.
REQ-010 NZCV  input  4  flags, N=bit3, Z=bit2, C=bit1, V=bit0.
REQ-011 ir_ready  input  1  consumer accepts head instruction.
REQ-012 ir_valid  output  1  queue head holds an instruction.
REQ-013 IR  output  32  head instruction (0 when empty).
REQ-014 PC  output  32  address of head instruction (0 when empty).
REQ-015 W_IR_valid  output  1  condition of head instruction passes under current NZCV.

Function
REQ-016 Fetch pointer fpc SHALL issue a ROM read (rom_addr = fpc[ADDR_W+1:2]) and advance by 4 (mod 2^32) in any cycle where entries occupied + read in flight < DEPTH and redirect is low.
REQ-017 Data returned by an issued read SHALL be pushed with its address the following edge; issue-to-ir_valid latency from an empty queue SHALL be 2 cycles.
REQ-018 A pop SHALL occur on an edge where ir_valid and ir_ready are both high; simultaneous push and pop SHALL keep the count unchanged.
REQ-019 The queue SHALL never overflow; push when full SHALL be impossible by REQ-016 reservation.
REQ-020 redirect SHALL, at that edge, empty the queue, discard any in-flight read data, ignore a coincident pop, and load fpc with {redirect_pc[31:2],2'b00}; issue resumes next cycle.
REQ-021 W_IR_valid SHALL decode IR[31:28] combinationally: 0 Z, 1 !Z, 2 C, 3 !C, 4 N, 5 !N, 6 V, 7 !V, 8 C&!Z, 9 !C|Z, A N==V, B N!=V, C !Z&(N==V), D Z|(N!=V), E and F 1.
REQ-022 W_IR_valid SHALL be 0 when ir_valid is 0.
REQ-023 rom_addr SHALL wrap modulo 2^ADDR_W while fpc continues to full 32-bit width.

Reset
REQ-024 While rst is low: fpc=PC_RESET, queue empty, in-flight flag clear, IR=0, PC=0, ir_valid=0, W_IR_valid=0, rom_addr=PC_RESET[ADDR_W+1:2].
REQ-025 Reset asserted mid-operation SHALL abandon in-flight reads; first issue occurs on the first edge after rst rises.

Configuration
REQ-026 With macro FETCH_COND_SKIP_EN defined, a head whose condition fails SHALL be popped automatically that edge without raising ir_valid, and W_IR_valid SHALL equal ir_valid.
REQ-027 Without FETCH_COND_SKIP_EN, every fetched instruction SHALL be presented; the consumer resolves W_IR_valid.

Verification
REQ-028 ROM words i -> 32'hE000_0000+i, ir_ready=1 after reset -> ir_valid at cycle 2, PC 0,4,8... one per cycle, IR matching.
REQ-029 ir_ready=0 for 10 cycles -> exactly DEPTH=4 entries held, rom_addr frozen, no loss on release.
REQ-030 redirect=1, redirect_pc=32'h23 while in-flight data pending -> queue empty next cycle, stale word never presented, next PC 32'h20.
REQ-031 Head IR=32'hC000_0000 with NZCV=4'b0100 -> W_IR_valid=0; NZCV=4'b1001 -> 1; IR=32'hD...,NZCV=4'b1000 -> 1.
REQ-032 With FETCH_COND_SKIP_EN, IR 32'h0... at head, Z=0 -> entry dropped, next PC presented; fpc 32'hFC with ADDR_W=6 -> rom_addr wraps to 0.
